// File: rtl/axi_default_slave.sv
// Default (error) slave for the AXI interconnect: sinks every unmapped
// transaction and answers it with DECERR on independent write and read paths.
module axi_default_slave #(
  parameter int WIDTH_CID = 4,
  parameter int WIDTH_ID  = 4,
  parameter int WIDTH_SID = WIDTH_CID + WIDTH_ID,
  parameter int WIDTH_AD  = 32,
  parameter int WIDTH_DA  = 32,
  parameter int WIDTH_DS  = WIDTH_DA / 8
) (
  input  logic                 ARESETn,
  input  logic                 ACLK,
  input  logic [WIDTH_SID-1:0] AWID,
  input  logic [WIDTH_AD-1:0]  AWADDR,
  input  logic [3:0]           AWLEN,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [WIDTH_SID-1:0] WID,
  input  logic [WIDTH_DA-1:0]  WDATA,
  input  logic [WIDTH_DS-1:0]  WSTRB,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [WIDTH_SID-1:0] BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  input  logic [WIDTH_SID-1:0] ARID,
  input  logic [WIDTH_AD-1:0]  ARADDR,
  input  logic [3:0]           ARLEN,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [WIDTH_SID-1:0] RID,
  output logic [WIDTH_DA-1:0]  RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic                 ready_en_reg;
  logic [WIDTH_SID-1:0] bid_reg;
  logic [WIDTH_SID-1:0] rid_reg;
  logic [3:0]           rlen_reg;
  logic [3:0]           beat_cnt_reg;

  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, AWLEN, WID, WDATA, WSTRB, ARADDR};

  // Address READYs stay low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) ready_en_reg <= 1'b0;
    else          ready_en_reg <= 1'b1;
  end

  // ---------------- write path ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_reg <= W_IDLE;
      bid_reg     <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (AWVALID && AWREADY) bid_reg <= AWID;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    BRESP        = 2'b00;
    BID          = bid_reg;
    case (w_state_reg)
      W_IDLE: begin
        AWREADY = ready_en_reg;
        if (AWVALID && ready_en_reg) w_state_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && WLAST) w_state_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = RESP_DECERR;
        if (BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // ---------------- read path ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_reg  <= R_IDLE;
      rid_reg      <= '0;
      rlen_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (ARVALID && ARREADY) begin
        rid_reg      <= ARID;
        rlen_reg     <= ARLEN;
        beat_cnt_reg <= '0;
      end else if (RVALID && RREADY && !RLAST) begin
        beat_cnt_reg <= beat_cnt_reg + 4'd1;
      end
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    ARREADY      = 1'b0;
    RVALID       = 1'b0;
    RLAST        = 1'b0;
    RRESP        = 2'b00;
    RID          = rid_reg;
    RDATA        = '0;
    case (r_state_reg)
      R_IDLE: begin
        ARREADY = ready_en_reg;
        if (ARVALID && ready_en_reg) r_state_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RRESP  = RESP_DECERR;
        RLAST  = (beat_cnt_reg == rlen_reg);
        if (RREADY && (beat_cnt_reg == rlen_reg)) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed bench for axi_default_slave: inputs driven and outputs checked on
// the falling edge of ACLK, expectations written out by hand.
module tb_axi_default_slave;

  localparam int SID = 8;

  logic            ARESETn, ACLK;
  logic [SID-1:0]  AWID, WID, BID, ARID, RID;
  logic [31:0]     AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]      AWLEN, ARLEN, WSTRB;
  logic            AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [1:0]      BRESP, RRESP;

  int checks = 0;
  int errors = 0;

  axi_default_slave dut (
    .ARESETn(ARESETn), .ACLK(ACLK),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  int beats;
  logic exp_last;

  initial begin
    ARESETn = 0; AWID = 0; WID = 0; ARID = 0; AWADDR = 32'h1000; WDATA = 0; ARADDR = 32'h2000;
    AWLEN = 0; ARLEN = 0; WSTRB = 4'hF; AWVALID = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARVALID = 0; RREADY = 0;

    // ---- reset release ----
    tick(); tick();
    chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0);
    chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);     chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);         chk("rst_rid", RID, 0);
    ARESETn = 1;
    tick();
    chk("rel_awready", AWREADY, 1); chk("rel_arready", ARREADY, 1);
    chk("rel_bresp", BRESP, 0);     chk("rel_rresp", RRESP, 0);
    $display("txn reset release done");

    // ---- single write, second AW refused until B completes ----
    AWID = 8'h35; AWVALID = 1;
    tick();
    chk("sw_awready_lo", AWREADY, 0); chk("sw_wready", WREADY, 1);
    AWID = 8'h77; WVALID = 1; WLAST = 1;
    tick();
    chk("sw_bvalid", BVALID, 1); chk("sw_bid", BID, 8'h35); chk("sw_bresp", BRESP, 2'b11);
    chk("sw_aw_refused", AWREADY, 0); chk("sw_wready_lo", WREADY, 0);
    WVALID = 0; WLAST = 0; BREADY = 1;
    tick();
    chk("sw_b_done", BVALID, 0); chk("sw_awready_back", AWREADY, 1);
    tick();
    chk("sw2_accepted", WREADY, 1); chk("sw2_awready_lo", AWREADY, 0);
    AWVALID = 0; WVALID = 1; WLAST = 1;
    tick();
    chk("sw2_bvalid", BVALID, 1); chk("sw2_bid", BID, 8'h77);
    WVALID = 0; WLAST = 0;
    tick();
    chk("sw2_b_done", BVALID, 0);
    BREADY = 0;
    $display("txn single write id=35 and queued write id=77 done");

    // ---- write burst with WVALID gaps and B stall ----
    AWID = 8'h42; AWLEN = 3; AWVALID = 1;
    tick();
    chk("wb_wready", WREADY, 1);
    AWVALID = 0;
    begin
      logic [6:0] vpat;
      logic [6:0] lpat;
      vpat = 7'b1010101;  // bit i = WVALID in step i
      lpat = 7'b1000000;  // only the 4th valid beat carries WLAST
      for (int i = 0; i < 7; i++) begin
        WVALID = vpat[i]; WLAST = lpat[i];
        tick();
        if (i < 6) begin
          chk("wb_no_b_yet", BVALID, 0); chk("wb_wready_hold", WREADY, 1);
        end
      end
    end
    WVALID = 0; WLAST = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wb_stall_bvalid", BVALID, 1); chk("wb_stall_bid", BID, 8'h42);
      chk("wb_stall_aw", AWREADY, 0);
      tick();
    end
    chk("wb_bvalid_last", BVALID, 1);
    BREADY = 1;
    tick();
    chk("wb_b_done", BVALID, 0); chk("wb_awready", AWREADY, 1);
    BREADY = 0;
    $display("txn write burst id=42 len=4 with stalls done");

    // ---- read burst, ARLEN=15, RREADY toggling ----
    ARID = 8'h1A; ARLEN = 15; ARVALID = 1;
    tick();
    chk("rb_arready_lo", ARREADY, 0);
    ARVALID = 0;
    beats = 0;
    for (int cyc = 0; cyc < 64 && beats < 16; cyc++) begin
      exp_last = (beats == 15);
      chk("rb_rvalid", RVALID, 1);    chk("rb_rid", RID, 8'h1A);
      chk("rb_rresp", RRESP, 2'b11);  chk("rb_rdata", RDATA, 0);
      chk("rb_rlast", RLAST, exp_last);
      RREADY = (cyc % 2 == 0);
      if (RREADY) beats++;
      tick();
    end
    RREADY = 0;
    chk("rb_beats", beats, 16);
    chk("rb_rvalid_end", RVALID, 0); chk("rb_arready_back", ARREADY, 1);
    $display("txn read burst id=1A beats=%0d done", beats);

    // ---- concurrent AW and AR ----
    AWID = 8'h11; AWVALID = 1; ARID = 8'h22; ARLEN = 0; ARVALID = 1;
    tick();
    chk("cc_awready", AWREADY, 0); chk("cc_arready", ARREADY, 0);
    chk("cc_wready", WREADY, 1);   chk("cc_rvalid", RVALID, 1);
    chk("cc_rlast", RLAST, 1);     chk("cc_rid", RID, 8'h22);
    AWVALID = 0; ARVALID = 0; WVALID = 1; WLAST = 1; RREADY = 1; BREADY = 1;
    tick();
    chk("cc_bvalid", BVALID, 1); chk("cc_bid", BID, 8'h11);
    chk("cc_r_done", RVALID, 0); chk("cc_arready_back", ARREADY, 1);
    WVALID = 0; WLAST = 0; RREADY = 0;
    tick();
    chk("cc_b_done", BVALID, 0); chk("cc_awready_back", AWREADY, 1);
    $display("txn concurrent write id=11 read id=22 done");

    // ---- early W before AW ----
    WVALID = 1; WLAST = 1;
    tick();
    chk("ew_wready_lo", WREADY, 0); chk("ew_bvalid_lo", BVALID, 0);
    tick();
    chk("ew_wready_lo2", WREADY, 0); chk("ew_awready", AWREADY, 1);
    AWID = 8'h5C; AWVALID = 1;
    tick();
    chk("ew_wready", WREADY, 1);
    AWVALID = 0;
    tick();
    chk("ew_bvalid", BVALID, 1); chk("ew_bid", BID, 8'h5C);
    WVALID = 0; WLAST = 0;
    tick();
    chk("ew_b_done", BVALID, 0);
    BREADY = 0;
    $display("txn early W then write id=5C done");

    // ---- mid-burst reset ----
    ARID = 8'h33; ARLEN = 7; ARVALID = 1;
    tick();
    chk("mr_rvalid", RVALID, 1);
    ARVALID = 0; RREADY = 1;
    tick(); tick();
    chk("mr_beat3_valid", RVALID, 1); chk("mr_beat3_last", RLAST, 0);
    ARESETn = 0;
    #1;
    chk("mr_rvalid_async", RVALID, 0); chk("mr_rid_clr", RID, 0);
    chk("mr_rresp_clr", RRESP, 0);     chk("mr_arready_clr", ARREADY, 0);
    RREADY = 0;
    tick();
    ARESETn = 1;
    tick();
    chk("mr_arready_back", ARREADY, 1); chk("mr_rvalid_idle", RVALID, 0);
    ARID = 8'h0F; ARLEN = 0; ARVALID = 1;
    tick();
    chk("mr_new_rvalid", RVALID, 1); chk("mr_new_rlast", RLAST, 1);
    chk("mr_new_rid", RID, 8'h0F);
    ARVALID = 0; RREADY = 1;
    tick();
    chk("mr_new_done", RVALID, 0); chk("mr_new_arready", ARREADY, 1);
    RREADY = 0;
    $display("txn mid-burst reset and single-beat read id=0F done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
